// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcode encoding, FSM states, default width.
package alu_pkg;

  localparam int unsigned AluWidth = 32;
  localparam int unsigned AluOpW   = 3;

  typedef enum logic [2:0] {
    AluAnd  = 3'd0,
    AluOr   = 3'd1,
    AluXor  = 3'd2,
    AluNor  = 3'd3,
    AluLess = 3'd4,
    AluAdd  = 3'd5,
    AluSub  = 3'd6,
    AluMod  = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StHold
  } ctrl_state_e;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issue-side controller for the multicycle ALU: one op in flight, operands held until We, result
// presented downstream via valid/ready. Define ALU_TIMEOUT_EN to add the WAIT watchdog and Out_Err.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH          = AluWidth,
  parameter int unsigned TAG_W          = 4,
  parameter int unsigned MIN_WAIT       = 1,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [WIDTH-1:0]  In_A,
  input  logic [WIDTH-1:0]  In_B,
  input  logic [2:0]        In_Op,
  input  logic [TAG_W-1:0]  In_Tag,
  output logic [WIDTH-1:0]  A,
  output logic [WIDTH-1:0]  B,
  output logic [2:0]        ALUOp,
  input  logic [WIDTH-1:0]  Alu_Result,
  input  logic              Alu_C,
  input  logic              Alu_We,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [WIDTH-1:0]  Out_Result,
  output logic              Out_C,
  output logic [2:0]        Out_Op,
  output logic [TAG_W-1:0]  Out_Tag,
`ifdef ALU_TIMEOUT_EN
  output logic              Out_Err,
`endif
  output logic              Busy
);

  localparam int unsigned   CntW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] MinWaitCnt = CntW'(MIN_WAIT);

  ctrl_state_e      r_state, w_state_d;
  logic [WIDTH-1:0] r_a, w_a_d;
  logic [WIDTH-1:0] r_b, w_b_d;
  logic [2:0]       r_op, w_op_d;
  logic [TAG_W-1:0] r_tag, w_tag_d;
  logic [CntW-1:0]  r_wait_cnt, w_wait_cnt_d;
  logic             r_out_valid, w_out_valid_d;
  logic [WIDTH-1:0] r_out_result, w_out_result_d;
  logic             r_out_c, w_out_c_d;
  logic [2:0]       r_out_op, w_out_op_d;
  logic [TAG_W-1:0] r_out_tag, w_out_tag_d;
`ifdef ALU_TIMEOUT_EN
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT_CYCLES);
  logic             r_out_err, w_out_err_d;
  logic             w_timeout;
`endif

  logic w_in_ready;
  logic w_accept;
  logic w_we_sampled;

  assign w_in_ready   = (r_state == StIdle) | ((r_state == StHold) & Out_Ready);
  assign w_accept     = In_Valid & w_in_ready;
  // Early We belongs to the previous op and must not complete this one.
  assign w_we_sampled = (r_state == StWait) & (r_wait_cnt >= MinWaitCnt) & Alu_We;
`ifdef ALU_TIMEOUT_EN
  assign w_timeout    = (r_state == StWait) & ~w_we_sampled & (r_wait_cnt >= TimeoutCnt);
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state      <= StIdle;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_tag        <= '0;
      r_wait_cnt   <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_c      <= 1'b0;
      r_out_op     <= '0;
      r_out_tag    <= '0;
`ifdef ALU_TIMEOUT_EN
      r_out_err    <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_d;
      r_a          <= w_a_d;
      r_b          <= w_b_d;
      r_op         <= w_op_d;
      r_tag        <= w_tag_d;
      r_wait_cnt   <= w_wait_cnt_d;
      r_out_valid  <= w_out_valid_d;
      r_out_result <= w_out_result_d;
      r_out_c      <= w_out_c_d;
      r_out_op     <= w_out_op_d;
      r_out_tag    <= w_out_tag_d;
`ifdef ALU_TIMEOUT_EN
      r_out_err    <= w_out_err_d;
`endif
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_a_d          = r_a;
    w_b_d          = r_b;
    w_op_d         = r_op;
    w_tag_d        = r_tag;
    w_wait_cnt_d   = r_wait_cnt;
    w_out_valid_d  = r_out_valid;
    w_out_result_d = r_out_result;
    w_out_c_d      = r_out_c;
    w_out_op_d     = r_out_op;
    w_out_tag_d    = r_out_tag;
`ifdef ALU_TIMEOUT_EN
    w_out_err_d    = r_out_err;
`endif

    unique case (r_state)
      StIdle: begin
        if (w_accept) w_state_d = StWait;
      end
      StWait: begin
        if (r_wait_cnt != '1) w_wait_cnt_d = r_wait_cnt + 1'b1;
        if (w_we_sampled) begin
          w_out_result_d = Alu_Result;
          w_out_c_d      = Alu_C;
          w_out_op_d     = r_op;
          w_out_tag_d    = r_tag;
          w_out_valid_d  = 1'b1;
          w_state_d      = StHold;
        end
`ifdef ALU_TIMEOUT_EN
        else if (w_timeout) begin
          w_out_result_d = '0;
          w_out_c_d      = 1'b0;
          w_out_op_d     = r_op;
          w_out_tag_d    = r_tag;
          w_out_err_d    = 1'b1;
          w_out_valid_d  = 1'b1;
          w_state_d      = StHold;
        end
`endif
      end
      StHold: begin
        // A new op may be taken in the same cycle the result drains, avoiding an IDLE bubble.
        if (Out_Ready) begin
          w_out_valid_d = 1'b0;
          w_state_d     = In_Valid ? StWait : StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_accept) begin
      w_a_d        = In_A;
      w_b_d        = In_B;
      w_op_d       = In_Op;
      w_tag_d      = In_Tag;
      w_wait_cnt_d = '0;
`ifdef ALU_TIMEOUT_EN
      w_out_err_d  = 1'b0;
`endif
    end
  end

  assign In_Ready   = w_in_ready;
  assign A          = r_a;
  assign B          = r_b;
  assign ALUOp      = r_op;
  assign Out_Valid  = r_out_valid;
  assign Out_Result = r_out_result;
  assign Out_C      = r_out_c;
  assign Out_Op     = r_out_op;
  assign Out_Tag    = r_out_tag;
  assign Busy       = (r_state != StIdle);
`ifdef ALU_TIMEOUT_EN
  assign Out_Err    = r_out_err;
`endif

endmodule
